// File: rtl/dram_pkg.sv
// Shared types for the DRAM request arbiter: FSM states, client ids, beat width.
package dram_pkg;

  localparam int BEAT_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_DATA  = 2'd2,
    ST_WR_DATA  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CL_WGT = 2'd0,
    CL_ACT = 2'd1,
    CL_WB  = 2'd2
  } client_e;

  // Round-robin successor in the fixed ring wgt -> act -> wb -> wgt.
  function automatic client_e next_client(input client_e c);
    case (c)
      CL_WGT:  next_client = CL_ACT;
      CL_ACT:  next_client = CL_WB;
      CL_WB:   next_client = CL_WGT;
      default: next_client = CL_WGT;
    endcase
  endfunction

endpackage

// File: rtl/dram_req_arb_rr_arb3.sv
// Combinational 3-way round-robin picker; ptr names the client with highest priority.
module rr_arb3
  import dram_pkg::*;
(
  input  logic [2:0] req,
  input  client_e    ptr,
  output logic       gnt_valid,
  output client_e    gnt_id
);

  client_e first_s, second_s, third_s;

  // Priority order rotated so that ptr is examined first.
  always_comb begin
    case (ptr)
      CL_ACT: begin
        first_s  = CL_ACT;
        second_s = CL_WB;
        third_s  = CL_WGT;
      end
      CL_WB: begin
        first_s  = CL_WB;
        second_s = CL_WGT;
        third_s  = CL_ACT;
      end
      default: begin
        first_s  = CL_WGT;
        second_s = CL_ACT;
        third_s  = CL_WB;
      end
    endcase
  end

  // First requester in rotated order wins.
  always_comb begin
    gnt_valid = 1'b1;
    gnt_id    = first_s;
    if (req[first_s]) begin
      gnt_id = first_s;
    end else if (req[second_s]) begin
      gnt_id = second_s;
    end else if (req[third_s]) begin
      gnt_id = third_s;
    end else begin
      gnt_valid = 1'b0;
      gnt_id    = CL_WGT;
    end
  end

endmodule

// File: rtl/dram_req_arb.sv
// Arbitrates two read clients and one writeback client onto a single DRAM port.
// Define DRAM_ARB_WR_PRIO_EN to give writeback absolute priority over reads.
module dram_req_arb
  import dram_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 28
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wgt_rd_req,
  input  logic [ADDR_W-1:0]   wgt_rd_addr,
  output logic                wgt_rd_gnt,
  output logic                wgt_rd_valid,
  input  logic                act_rd_req,
  input  logic [ADDR_W-1:0]   act_rd_addr,
  output logic                act_rd_gnt,
  output logic                act_rd_valid,
  output logic [BEAT_W-1:0]   cl_rd_data,
  input  logic                wb_wr_req,
  input  logic [ADDR_W-3:0]   wb_wr_addr,
  input  logic [BEAT_W-1:0]   wb_wr_data,
  output logic                wb_wr_gnt,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_gnt,
  input  logic                rd_valid,
  input  logic [BEAT_W-1:0]   rd_data,
  output logic                wr_req,
  output logic [ADDR_W-3:0]   wr_addr,
  output logic [BEAT_W-1:0]   wr_data,
  input  logic                wr_gnt,
  output logic                busy
);

  localparam int              CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e            state_r, state_s;
  client_e           owner_r, ptr_r, pick_id_s, rr_id_s;
  logic [ADDR_W-1:0] addr_r, pick_addr_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [2:0]        arb_req_s;
  logic              rr_valid_s, pick_valid_s, owner_req_s;
  logic              rd_beat_s, wr_beat_s, last_beat_s;

`ifdef DRAM_ARB_WR_PRIO_EN
  assign arb_req_s = {1'b0, act_rd_req, wgt_rd_req};
`else
  assign arb_req_s = {wb_wr_req, act_rd_req, wgt_rd_req};
`endif

  rr_arb3 u_rr_arb3 (
    .req       (arb_req_s),
    .ptr       (ptr_r),
    .gnt_valid (rr_valid_s),
    .gnt_id    (rr_id_s)
  );

  // Winner of the current IDLE cycle and the address it presents.
  always_comb begin
`ifdef DRAM_ARB_WR_PRIO_EN
    if (wb_wr_req) begin
      pick_valid_s = 1'b1;
      pick_id_s    = CL_WB;
    end else begin
      pick_valid_s = rr_valid_s;
      pick_id_s    = rr_id_s;
    end
`else
    pick_valid_s = rr_valid_s;
    pick_id_s    = rr_id_s;
`endif
    case (pick_id_s)
      CL_ACT:  pick_addr_s = act_rd_addr;
      CL_WB:   pick_addr_s = {2'b00, wb_wr_addr};
      default: pick_addr_s = wgt_rd_addr;
    endcase
  end

  // Request level of the client that currently owns the port.
  always_comb begin
    case (owner_r)
      CL_ACT:  owner_req_s = act_rd_req;
      CL_WB:   owner_req_s = wb_wr_req;
      default: owner_req_s = wgt_rd_req;
    endcase
  end

  assign rd_beat_s   = (state_r == ST_RD_DATA) && rd_valid;
  assign wr_beat_s   = (state_r == ST_WR_DATA) && wr_gnt;
  assign last_beat_s = (rd_beat_s || wr_beat_s) && (beat_cnt_r == LAST_CNT);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a read owner that drops its request before rd_gnt forfeits.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s = (pick_id_s == CL_WB) ? ST_WR_DATA : ST_RD_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        if (rd_gnt) begin
          state_s = ST_RD_DATA;
        end else if (!owner_req_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RD_ISSUE;
        end
      end
      ST_RD_DATA, ST_WR_DATA: begin
        if (last_beat_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Owner, base address, beat counter and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_r    <= CL_WGT;
      ptr_r      <= CL_WGT;
      addr_r     <= {ADDR_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            owner_r    <= pick_id_s;
            addr_r     <= pick_addr_s;
            beat_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_RD_ISSUE: begin
          if (rd_gnt) begin
            beat_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_RD_DATA, ST_WR_DATA: begin
          if (last_beat_s) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            ptr_r      <= next_client(owner_r);
          end else if (rd_beat_s || wr_beat_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          beat_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign cl_rd_data = rd_data;

  // Output decode; everything except the data broadcast is zero outside its state.
  always_comb begin
    wgt_rd_gnt   = 1'b0;
    act_rd_gnt   = 1'b0;
    wgt_rd_valid = 1'b0;
    act_rd_valid = 1'b0;
    wb_wr_gnt    = 1'b0;
    rd_req       = 1'b0;
    rd_addr      = {ADDR_W{1'b0}};
    wr_req       = 1'b0;
    wr_addr      = {(ADDR_W-2){1'b0}};
    wr_data      = {BEAT_W{1'b0}};
    busy         = (state_r != ST_IDLE);
    case (state_r)
      ST_RD_ISSUE: begin
        rd_req     = 1'b1;
        rd_addr    = addr_r;
        wgt_rd_gnt = rd_gnt && (owner_r == CL_WGT);
        act_rd_gnt = rd_gnt && (owner_r == CL_ACT);
      end
      ST_RD_DATA: begin
        wgt_rd_valid = rd_valid && (owner_r == CL_WGT);
        act_rd_valid = rd_valid && (owner_r == CL_ACT);
      end
      ST_WR_DATA: begin
        wr_req    = 1'b1;
        wr_addr   = addr_r[ADDR_W-3:0] + (ADDR_W-2)'(beat_cnt_r);
        wr_data   = wb_wr_data;
        wb_wr_gnt = wr_gnt;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dram_req_arb.sv
// Randomized self-checking bench for dram_req_arb against a transaction-level arbitration model.
module tb_dram_req_arb;

  localparam int BL = 4;
  localparam int AW = 28;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          wgt_rd_req = 1'b0, act_rd_req = 1'b0, wb_wr_req = 1'b0;
  logic [AW-1:0] wgt_rd_addr = '0, act_rd_addr = '0;
  logic          wgt_rd_gnt, act_rd_gnt, wgt_rd_valid, act_rd_valid;
  logic [127:0]  cl_rd_data;
  logic [AW-3:0] wb_wr_addr = '0;
  logic [127:0]  wb_wr_data = '0;
  logic          wb_wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt = 1'b0, rd_valid = 1'b0;
  logic [127:0]  rd_data = '0;
  logic          wr_req;
  logic [AW-3:0] wr_addr;
  logic [127:0]  wr_data;
  logic          wr_gnt = 1'b0;
  logic          busy;

  dram_req_arb #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .wgt_rd_req(wgt_rd_req), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_gnt(wgt_rd_gnt), .wgt_rd_valid(wgt_rd_valid),
    .act_rd_req(act_rd_req), .act_rd_addr(act_rd_addr), .act_rd_gnt(act_rd_gnt), .act_rd_valid(act_rd_valid),
    .cl_rd_data(cl_rd_data),
    .wb_wr_req(wb_wr_req), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .wb_wr_gnt(wb_wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            errors = 0;
  int            m_ptr  = 0;   // model pointer: 0 wgt, 1 act, 2 wb
  logic [AW-1:0] cl_addr [2];
  logic [AW-3:0] wb_base;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Arbitration rule: first requester in ring order starting at the pointer.
  function automatic int model_pick(input bit [2:0] req, input int ptr);
`ifdef DRAM_ARB_WR_PRIO_EN
    if (req[2]) return 2;
`endif
    for (int i = 0; i < 3; i++) begin
      if (req[(ptr + i) % 3]) return (ptr + i) % 3;
    end
    return -1;
  endfunction

  task automatic set_reqs(input bit [2:0] r);
    wgt_rd_req = r[0];
    act_rd_req = r[1];
    wb_wr_req  = r[2];
  endtask

  task automatic recover();
    @(negedge clock);
    set_reqs(3'b000);
    rd_gnt = 1'b0; rd_valid = 1'b0; wr_gnt = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_ptr = 0;
  endtask

  // Returns 0 when a read is issued, 2 when a write is issued, -1 on timeout.
  task automatic wait_issue(output int seen);
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock); #1;
      if (rd_req === 1'b1) begin seen = 0; return; end
      if (wr_req === 1'b1) begin seen = 2; return; end
    end
    checks++; errors++;
    $display("FAIL issue_timeout got no rd_req/wr_req expected one within 20 cycles");
  endtask

  task automatic serve_read(input int exp, input int lat, input int nbeats);
    logic [1:0] exp_v;
    int gap;
    exp_v = (exp == 0) ? 2'b01 : 2'b10;
    checks++;
    if (rd_addr !== cl_addr[exp]) begin
      errors++; $display("FAIL rd_addr got %0h expected %0h", rd_addr, cl_addr[exp]);
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clock);
      rd_valid = 1'($urandom_range(0, 1)); rd_data = rnd128();
      #1; checks++;
      if ({act_rd_valid, wgt_rd_valid, act_rd_gnt, wgt_rd_gnt} !== 4'b0000 || rd_req !== 1'b1) begin
        errors++; $display("FAIL issue_wait got v/g %b rd_req %b expected 0000 1",
                           {act_rd_valid, wgt_rd_valid, act_rd_gnt, wgt_rd_gnt}, rd_req);
      end
    end
    @(negedge clock);
    rd_valid = 1'b0; rd_gnt = 1'b1;
    #1; checks++;
    if ({act_rd_gnt, wgt_rd_gnt} !== exp_v) begin
      errors++; $display("FAIL rd_gnt_owner got %b expected %b", {act_rd_gnt, wgt_rd_gnt}, exp_v);
    end
    for (int b = 0; b < nbeats; b++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        rd_gnt = 1'b0; rd_valid = 1'b0;
        if (exp == 0) wgt_rd_req = 1'b0; else act_rd_req = 1'b0;
        #1; checks++;
        if ({act_rd_valid, wgt_rd_valid} !== 2'b00 || busy !== 1'b1) begin
          errors++; $display("FAIL beat_gap beat %0d got valid %b busy %b expected 00 1",
                             b, {act_rd_valid, wgt_rd_valid}, busy);
        end
      end
      @(negedge clock);
      rd_gnt = 1'b0; rd_valid = 1'b1; rd_data = rnd128();
      if (exp == 0) wgt_rd_req = 1'b0; else act_rd_req = 1'b0;
      #1; checks++;
      if ({act_rd_valid, wgt_rd_valid} !== exp_v || cl_rd_data !== rd_data) begin
        errors++; $display("FAIL rd_beat %0d got valid %b data %h expected %b %h",
                           b, {act_rd_valid, wgt_rd_valid}, cl_rd_data, exp_v, rd_data);
      end
    end
    if (nbeats == BL) begin
      @(negedge clock);
      rd_valid = 1'b0;
      #1; checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL busy_after_read got %b expected 0", busy);
      end
    end
  endtask

  task automatic serve_write(input bit full_rate);
    int beats, cyc, pulses;
    logic [AW-3:0] ea;
    logic g;
    beats = 0; cyc = 0; pulses = 0;
    while (beats < BL && cyc < 40) begin
      @(negedge clock);
      g = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
      wr_gnt = g; wb_wr_data = rnd128();
      #1;
      ea = wb_base + beats[AW-3:0];
      checks++;
      if (wr_req !== 1'b1 || wr_addr !== ea || wr_data !== wb_wr_data || wb_wr_gnt !== g) begin
        errors++; $display("FAIL wr_beat %0d got req %b addr %h gnt %b expected 1 %h %b",
                           beats, wr_req, wr_addr, wb_wr_gnt, ea, g);
      end
      if (wb_wr_gnt === 1'b1) pulses++;
      if (g) beats++;
      cyc++;
    end
    @(negedge clock);
    wr_gnt = 1'b0; wb_wr_req = 1'b0;
    #1; checks++;
    if (busy !== 1'b0 || pulses != BL) begin
      errors++; $display("FAIL write_end got busy %b pulses %0d expected 0 %0d", busy, pulses, BL);
    end
  endtask

  task automatic arb_round(input bit [2:0] sub);
    int exp, seen;
    @(negedge clock);
    cl_addr[0] = AW'($urandom); cl_addr[1] = AW'($urandom); wb_base = (AW-2)'($urandom);
    wgt_rd_addr = cl_addr[0]; act_rd_addr = cl_addr[1]; wb_wr_addr = wb_base;
    set_reqs(sub);
    exp = model_pick(sub, m_ptr);
    wait_issue(seen);
    if (seen < 0) begin recover(); return; end
    checks++;
    if ((seen == 2) != (exp == 2)) begin
      errors++; $display("FAIL winner_kind req %b got %0d expected %0d", sub, seen, exp);
      recover(); return;
    end
    if (seen == 2) serve_write(1'b0);
    else serve_read(exp, $urandom_range(0, 3), BL);
    m_ptr = (exp + 1) % 3;
    set_reqs(3'b000);
  endtask

  task automatic test_reset();
    rd_data = rnd128();
    #2; checks++;
    if ({rd_req, wr_req, busy, wb_wr_gnt, wgt_rd_gnt, act_rd_gnt, wgt_rd_valid, act_rd_valid} !== 8'h00
        || cl_rd_data !== rd_data) begin
      errors++; $display("FAIL reset_outputs got %b expected 00000000", {rd_req, wr_req, busy, wb_wr_gnt});
    end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock); #1; checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy %b rd_req %b expected 0 0", busy, rd_req);
    end
  endtask

  task automatic test_single_read();
    int seen;
    @(negedge clock);
    cl_addr[0] = 28'h0000100; wgt_rd_addr = cl_addr[0];
    set_reqs(3'b001);
    wait_issue(seen);
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL single_read_issue got %0d expected 0", seen); recover(); return;
    end
    serve_read(0, 3, BL);
    m_ptr = 1;
    set_reqs(3'b000);
  endtask

  task automatic test_all_three();
    for (int r = 0; r < 7; r++) arb_round(3'b111);
`ifdef DRAM_ARB_WR_PRIO_EN
    for (int r = 0; r < 4; r++) arb_round(3'b011);
`endif
  endtask

  task automatic test_wrap();
    int seen;
    @(negedge clock);
    wb_base = 26'h3FFFFFE; wb_wr_addr = wb_base;
    set_reqs(3'b100);
    wait_issue(seen);
    checks++;
    if (seen != 2) begin
      errors++; $display("FAIL wrap_issue got %0d expected 2", seen); recover(); return;
    end
    serve_write(1'b1);
    m_ptr = 0;
    set_reqs(3'b000);
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    @(negedge clock);
    cl_addr[0] = AW'($urandom); wgt_rd_addr = cl_addr[0];
    set_reqs(3'b001);
    wait_issue(seen);
    if (seen != 0) begin
      checks++; errors++; $display("FAIL mid_issue got %0d expected 0", seen); recover(); return;
    end
    serve_read(0, 1, 2);
    @(negedge clock);
    rd_valid = 1'b0; reset_n = 1'b0;
    #1; checks++;
    if ({rd_req, wr_req, busy, wgt_rd_gnt, act_rd_gnt, wgt_rd_valid, act_rd_valid, wb_wr_gnt} !== 8'h00
        || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL async_reset got busy %b rd_req %b rd_addr %h expected 0 0 0", busy, rd_req, rd_addr);
    end
    @(negedge clock); reset_n = 1'b1; m_ptr = 0;
    arb_round(3'b010);
  endtask

  task automatic test_spurious();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      rd_valid = 1'b1; rd_data = rnd128();
      #1; checks++;
      if ({act_rd_valid, wgt_rd_valid} !== 2'b00 || busy !== 1'b0 || cl_rd_data !== rd_data) begin
        errors++; $display("FAIL spurious_valid got %b busy %b expected 00 0", {act_rd_valid, wgt_rd_valid}, busy);
      end
    end
    @(negedge clock); rd_valid = 1'b0;
    arb_round(3'b001);
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) arb_round(3'($urandom_range(1, 7)));
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_all_three();
    test_wrap();
    test_reset_mid_burst();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_req_arb.md
DRAM_REQ_ARB -- requirements
Module: dram_req_arb

Interface
REQ-001 Parameter BURST_LEN, default 4: beats per granted transaction (1..16).
REQ-002 Parameter ADDR_W, default 28: read address width; write address is ADDR_W-2 bits.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 wgt_rd_req / act_rd_req  input  1 each  client read request; held with address until its gnt.
REQ-006 wgt_rd_addr / act_rd_addr  input  ADDR_W each  client burst base address.
REQ-007 wgt_rd_gnt / act_rd_gnt  output  1 each  one-cycle pulse when DRAM accepts that client's read.
REQ-008 wgt_rd_valid / act_rd_valid  output  1 each  rd_valid steered to the owning client.
REQ-009 cl_rd_data  output  128  rd_data broadcast to all clients unregistered.
REQ-010 wb_wr_req  input  1  writeback request; held until burst ends.
REQ-011 wb_wr_addr  input  ADDR_W-2  writeback base address.
REQ-012 wb_wr_data  input  128  current write beat.
REQ-013 wb_wr_gnt  output  1  pulse per accepted write beat; client advances data.
REQ-014 rd_req / rd_addr  output  1 / ADDR_W  DRAM read request and address.
REQ-015 rd_gnt / rd_valid / rd_data  input  1 / 1 / 128  DRAM read accept, beat valid, beat data.
REQ-016 wr_req / wr_addr / wr_data  output  1 / ADDR_W-2 / 128  DRAM write request, beat address, beat data.
REQ-017 wr_gnt  input  1  DRAM accepts current write beat.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, RD_ISSUE, RD_DATA, WR_DATA.
REQ-020 IDLE: if any request, pick winner per REQ-026/027, latch owner and address, go to RD_ISSUE (read) or WR_DATA (write) next cycle; grants never issued from IDLE.
REQ-021 RD_ISSUE: rd_req=1, rd_addr=latched address; on rd_gnt pulse owner's *_rd_gnt same cycle, clear beat_cnt, go to RD_DATA.
REQ-022 RD_DATA: each rd_valid increments beat_cnt and asserts owner's *_rd_valid same cycle; on BURST_LEN-th beat go to IDLE.
REQ-023 WR_DATA: wr_req=1, wr_addr=base+beat_cnt (modulo 2^(ADDR_W-2), wrap permitted), wr_data=wb_wr_data; each wr_gnt pulses wb_wr_gnt and increments beat_cnt; after BURST_LEN-th beat go to IDLE.
REQ-024 rd_valid outside RD_DATA shall be ignored: no client valid asserted, no counter change.
REQ-025 Only one transaction outstanding; minimum one IDLE cycle between bursts.
REQ-026 Default arbitration: 3-way round-robin wgt->act->wb; pointer moves to requester after winner when burst completes.
REQ-027 Simultaneous requests resolved solely by pointer; request deasserted before grant is forfeited without error.
REQ-028 beat_cnt width $clog2(BURST_LEN+1); never exceeds BURST_LEN.

Reset
REQ-029 reset_n low, at any time including mid-burst: state=IDLE, pointer=wgt, beat_cnt=0, all outputs 0 except cl_rd_data (combinational rd_data); in-flight burst abandoned.

Configuration
REQ-030 Macro DRAM_ARB_WR_PRIO_EN defined: in IDLE wb_wr_req wins over any read; reads round-robin between wgt/act only.
REQ-031 Macro undefined: REQ-026 applies unchanged.

Structure
REQ-032 Package dram_pkg holds state enum type, client-id enum (CL_WGT, CL_ACT, CL_WB), beat width 128.
REQ-033 Sub-module rr_arb3 (combinational 3-way round-robin picker with pointer input) is natural; FSM stays in top.

Verification
REQ-034 wgt_rd_req alone, addr 0x100, rd_gnt after 3 cycles, 4 rd_valid -> one wgt_rd_gnt pulse, 4 wgt_rd_valid, act_rd_valid never high, busy drops after 4th beat.
REQ-035 wgt+act+wb requesting together, macro undefined -> grant order wgt, act, wb, wgt repeating.
REQ-036 Same stimulus, DRAM_ARB_WR_PRIO_EN defined -> wb first, then wgt, act alternate while wb idle.
REQ-037 wb burst base 0x3FFFFFE, wr_gnt every cycle -> wr_addr 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1; four wb_wr_gnt pulses.
REQ-038 reset_n low after 2nd read beat -> outputs 0 asynchronously; after release, new act request completes full 4-beat burst.
REQ-039 Spurious rd_valid in IDLE -> no client valid, beat_cnt stays 0.
